text_console_writer: RTL and testbench

Byte-stream terminal front end for the VGA character generator. Accepts ASCII characters over a valid/ready handshake, keeps a cursor, and writes 16-bit `{attribute, char}` cells into the character RAM through its CPU-side port. Handles CR, LF, BS and form feed, wraps at line end, and scrolls the screen up by one row via RAM-to-RAM copy. Sits directly upstream of the character generator's CPU port and replaces a soft CPU for simple text output.

---
 rtl/text_console_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream terminal front end for the character RAM.
// Writes {attr,char} cells, tracks a cursor, wraps lines and scrolls by RAM copy.

module text_console_writer #(
    parameter int         N_COL        = 240,
    parameter int         N_ROW        = 67,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F,
    parameter int         SYNC_VBLANK  = 0
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [7:0]  in_attr,
    input  logic        vBlank,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic        ram_oe,
    output logic [15:0] ram_dataOut,
    input  logic [15:0] ram_dataIn,
    output logic [15:0] cursor_col,
    output logic [15:0] cursor_row
);

    localparam logic [2:0] S_CLEAR      = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_SCROLL_RD  = 3'd3;
    localparam logic [2:0] S_SCROLL_WR  = 3'd4;
    localparam logic [2:0] S_SCROLL_CLR = 3'd5;

    localparam int          TOTAL     = N_COL * N_ROW;
    localparam logic [15:0] COL_W     = 16'(N_COL);
    localparam logic [15:0] LAST_COL  = 16'(N_COL - 1);
    localparam logic [15:0] LAST_ROW  = 16'(N_ROW - 1);
    localparam logic [15:0] LAST_CELL = 16'(TOTAL - 1);
    localparam logic [15:0] LAST_BASE = 16'((N_ROW - 1) * N_COL);
    localparam logic [15:0] SCR_END   = 16'(TOTAL - 1 - N_COL);
    localparam logic [15:0] BLANK     = {DEFAULT_ATTR, 8'h20};

    logic [2:0]  state;
    logic        run;
    logic [15:0] addr;
    logic [15:0] cur_addr;
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] wdata;
    logic        reread;
    logic        vb_s1;
    logic        vb_s2;
    logic        go;
    logic        accept;
    logic        we_state;
    logic        is_cr;
    logic        is_lf;
    logic        is_bs;
    logic        is_ff;

    // go=0 turns any would-be write cycle into a stall
    assign go     = (SYNC_VBLANK == 0) || vb_s2;
    assign accept = in_valid && in_ready;

    assign is_cr = (in_char == 8'h0D);
    assign is_lf = (in_char == 8'h0A);
    assign is_bs = (in_char == 8'h08);
    assign is_ff = (in_char == 8'h0C);

    assign in_ready   = run && (state == S_IDLE);
    assign ram_oe     = run && (state == S_SCROLL_RD);
    assign ram_we     = we_state && go;
    assign ram_addr   = addr;
    assign cursor_col = col;
    assign cursor_row = row;

    // Which states present a write cycle; a copy waiting on a re-read does not
    always_comb begin
        we_state = 1'b0;
        if (run) begin
            case (state)
                S_CLEAR, S_WRITE, S_SCROLL_CLR: we_state = 1'b1;
                S_SCROLL_WR:                    we_state = !reread;
                default:                        we_state = 1'b0;
            endcase
        end
    end

    // Write data source per state; scroll copies pass read data straight through
    always_comb begin
        ram_dataOut = 16'h0000;
        if (run) begin
            case (state)
                S_CLEAR, S_SCROLL_CLR: ram_dataOut = BLANK;
                S_WRITE:               ram_dataOut = wdata;
                S_SCROLL_WR:           ram_dataOut = ram_dataIn;
                default:               ram_dataOut = 16'h0000;
            endcase
        end
    end

    // Two-flop synchroniser for vBlank from the pixel domain
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_s1 <= 1'b0;
            vb_s2 <= 1'b0;
        end else begin
            vb_s1 <= vBlank;
            vb_s2 <= vb_s1;
        end
    end

    // Main FSM: cursor, incremental cell address and RAM sequencing
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            run      <= 1'b0;
            addr     <= 16'h0000;
            cur_addr <= 16'h0000;
            col      <= 16'h0000;
            row      <= 16'h0000;
            wdata    <= 16'h0000;
            reread   <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (go) begin
                        if (addr == LAST_CELL) begin
                            state    <= S_IDLE;
                            addr     <= 16'h0000;
                            cur_addr <= 16'h0000;
                            col      <= 16'h0000;
                            row      <= 16'h0000;
                        end else begin
                            addr <= addr + 16'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_cr: begin
                                col      <= 16'h0000;
                                cur_addr <= cur_addr - col;
                            end
                            is_lf: begin
                                col <= 16'h0000;
                                if (row == LAST_ROW) begin
                                    cur_addr <= LAST_BASE;
                                    addr     <= COL_W;
                                    state    <= S_SCROLL_RD;
                                end else begin
                                    row      <= row + 16'd1;
                                    cur_addr <= cur_addr - col + COL_W;
                                end
                            end
                            is_bs: begin
                                if (col != 16'h0000) begin
                                    col      <= col - 16'd1;
                                    cur_addr <= cur_addr - 16'd1;
                                end
                            end
                            is_ff: begin
                                addr  <= 16'h0000;
                                state <= S_CLEAR;
                            end
                            default: begin
                                addr  <= cur_addr;
                                wdata <= {in_attr, in_char};
                                state <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (go) begin
                        state <= S_IDLE;
                        if (col == LAST_COL) begin
                            col <= 16'h0000;
                            if (row == LAST_ROW) begin
                                cur_addr <= LAST_BASE;
                                addr     <= COL_W;
                                state    <= S_SCROLL_RD;
                            end else begin
                                row      <= row + 16'd1;
                                cur_addr <= cur_addr + 16'd1;
                            end
                        end else begin
                            col      <= col + 16'd1;
                            cur_addr <= cur_addr + 16'd1;
                        end
                    end
                end
                S_SCROLL_RD: begin
                    addr  <= addr - COL_W;
                    state <= S_SCROLL_WR;
                end
                S_SCROLL_WR: begin
                    if (reread) begin
                        if (go) begin
                            reread <= 1'b0;
                            addr   <= addr + COL_W;
                            state  <= S_SCROLL_RD;
                        end
                    end else if (!go) begin
                        reread <= 1'b1;
                    end else if (addr == SCR_END) begin
                        addr  <= LAST_BASE;
                        state <= S_SCROLL_CLR;
                    end else begin
                        addr  <= addr + COL_W + 16'd1;
                        state <= S_SCROLL_RD;
                    end
                end
                S_SCROLL_CLR: begin
                    if (go) begin
                        if (addr == LAST_CELL) begin
                            state <= S_IDLE;
                        end else begin
                            addr <= addr + 16'd1;
                        end
                    end
                end
                default: begin
                    addr  <= 16'h0000;
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed checks of text_console_writer on a 4x3 screen.
// A behavioural RAM and write/read logs stand in for the character generator.

module tb_text_console_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char  = 8'h00;
    logic [7:0]  in_attr  = 8'h00;
    logic        vblank   = 1'b1;
    logic        in_ready;
    logic        ram_we;
    logic        ram_oe;
    logic [15:0] ram_addr;
    logic [15:0] ram_dataOut;
    logic [15:0] ram_dataIn = 16'h0000;
    logic [15:0] cursor_col;
    logic [15:0] cursor_row;

    logic        in_valid2 = 1'b0;
    logic [7:0]  in_char2  = 8'h00;
    logic [7:0]  in_attr2  = 8'h00;
    logic        in_ready2;
    logic        ram_we2;
    logic        ram_oe2;
    logic [15:0] ram_addr2;
    logic [15:0] ram_dataOut2;
    logic [15:0] ram_dataIn2 = 16'h0000;
    logic [15:0] cursor_col2;
    logic [15:0] cursor_row2;

    text_console_writer #(.N_COL(4), .N_ROW(3), .DEFAULT_ATTR(8'h0F), .SYNC_VBLANK(0)) dut (
        .cpu_clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_attr(in_attr), .vBlank(vblank),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_dataOut(ram_dataOut), .ram_dataIn(ram_dataIn),
        .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    text_console_writer #(.N_COL(4), .N_ROW(3), .DEFAULT_ATTR(8'h0F), .SYNC_VBLANK(1)) dut_vb (
        .cpu_clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_char(in_char2), .in_attr(in_attr2), .vBlank(vblank),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_oe(ram_oe2),
        .ram_dataOut(ram_dataOut2), .ram_dataIn(ram_dataIn2),
        .cursor_col(cursor_col2), .cursor_row(cursor_row2)
    );

    logic [15:0] mem [0:15];
    logic [15:0] wa_q [$];
    logic [15:0] wd_q [$];
    logic [15:0] ra_q [$];
    int overlap = 0;
    int w2_cnt  = 0;
    int checks  = 0;
    int errors  = 0;

    // Synchronous-read RAM plus logs of every write and read
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[3:0]] <= ram_dataOut;
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_dataOut);
        end
        if (ram_oe) begin
            ram_dataIn <= mem[ram_addr[3:0]];
            ra_q.push_back(ram_addr);
        end
        if (ram_we && ram_oe) overlap <= overlap + 1;
        if (ram_we2) w2_cnt <= w2_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", in_ready, 1);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_char  = c;
        in_attr  = a;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_count"}, wa_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i >= wa_q.size() || wa_q[i] != 16'(i) || wd_q[i] != 16'h0F20) bad++;
        end
        chk({tag, "_cells"}, bad, 0);
    endtask

    typedef struct {
        logic [7:0]  ch;
        logic [7:0]  at;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] col;
        logic [15:0] row;
    } vec_t;

    vec_t vt [5];
    logic [15:0] em [12];

    initial begin
        int n;
        int bad;
        int base;
        logic [15:0] e;

        vt[0] = '{8'h41, 8'h1E, 16'd0, 16'h1E41, 16'd1, 16'd0};
        vt[1] = '{8'h42, 8'h2F, 16'd1, 16'h2F42, 16'd2, 16'd0};
        vt[2] = '{8'h43, 8'h07, 16'd2, 16'h0743, 16'd3, 16'd0};
        vt[3] = '{8'h44, 8'h70, 16'd3, 16'h7044, 16'd0, 16'd1};
        vt[4] = '{8'h45, 8'h4E, 16'd4, 16'h4E45, 16'd1, 16'd1};
        em = '{16'h0769, 16'h076A, 16'h076B, 16'h0F20,
               16'h0777, 16'h0778, 16'h0779, 16'h077A,
               16'h0F20, 16'h0F20, 16'h0F20, 16'h0F20};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_dataOut, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);
        clear_logs();
        rst_n = 1'b1;
        wait_ready(n);
        check_clear("boot");
        chk("boot_col", cursor_col, 0);
        chk("boot_row", cursor_row, 0);

        clear_logs();
        for (int i = 0; i < 5; i++) begin
            send(vt[i].ch, vt[i].at);
            chk("vec_we", ram_we, 1);
            chk("vec_addr", ram_addr, vt[i].addr);
            chk("vec_data", ram_dataOut, vt[i].data);
            chk("vec_busy", in_ready, 0);
            @(negedge clk);
            chk("vec_we_off", ram_we, 0);
            chk("vec_col", cursor_col, vt[i].col);
            chk("vec_row", cursor_row, vt[i].row);
            chk("vec_ready", in_ready, 1);
        end
        chk("vec_writes", wa_q.size(), 5);

        clear_logs();
        send(8'h0D, 8'h00);
        chk("cr_ready", in_ready, 1);
        chk("cr_col", cursor_col, 0);
        chk("cr_row", cursor_row, 1);
        send(8'h08, 8'h00);
        chk("bs0_ready", in_ready, 1);
        chk("bs0_col", cursor_col, 0);
        chk("bs0_row", cursor_row, 1);
        send(8'h58, 8'h07);
        @(negedge clk);
        chk("x_col", cursor_col, 1);
        send(8'h08, 8'h00);
        chk("bs_col", cursor_col, 0);
        chk("bs_row", cursor_row, 1);
        chk("ctrl_writes", wa_q.size(), 1);
        chk("x_addr", wa_q[0], 16'd4);
        chk("x_data", wd_q[0], 16'h0758);

        clear_logs();
        send(8'h0C, 8'h00);
        chk("ff_busy", in_ready, 0);
        wait_ready(n);
        check_clear("ff");
        chk("ff_col", cursor_col, 0);
        chk("ff_row", cursor_row, 0);

        for (int i = 0; i < 11; i++) send(8'(8'h61 + i), 8'h07);
        wait_ready(n);
        chk("fill_col", cursor_col, 3);
        chk("fill_row", cursor_row, 2);

        clear_logs();
        send(8'h0A, 8'h00);
        wait_ready(n);
        chk("scroll_cycles", n, 20);
        chk("scroll_reads_n", ra_q.size(), 8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= ra_q.size() || ra_q[i] != 16'(i + 4)) bad++;
        end
        chk("scroll_reads", bad, 0);
        chk("scroll_writes_n", wa_q.size(), 12);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            e = (i + 4 < 11) ? {8'h07, 8'(8'h65 + i)} : 16'h0F20;
            if (i >= wa_q.size() || wa_q[i] != 16'(i) || wd_q[i] != e) bad++;
        end
        chk("scroll_writes", bad, 0);
        chk("scroll_col", cursor_col, 0);
        chk("scroll_row", cursor_row, 2);

        clear_logs();
        send(8'h77, 8'h07);
        send(8'h78, 8'h07);
        send(8'h79, 8'h07);
        send(8'h7A, 8'h07);
        wait_ready(n);
        chk("wrap_writes_n", wa_q.size(), 16);
        chk("wrap_col", cursor_col, 0);
        chk("wrap_row", cursor_row, 2);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem[i] !== em[i]) bad++;
        end
        chk("wrap_screen", bad, 0);

        send(8'h0A, 8'h00);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_oe", ram_oe, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_data", ram_dataOut, 0);
        chk("mid_rst_col", cursor_col, 0);
        chk("mid_rst_row", cursor_row, 0);
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check_clear("rerst");
        chk("rerst_col", cursor_col, 0);

        n = 0;
        while (!in_ready2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("v_ready", in_ready2, 1);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        base = w2_cnt;
        in_valid2 = 1'b1;
        in_char2  = 8'h5A;
        in_attr2  = 8'h1E;
        @(negedge clk);
        in_valid2 = 1'b0;
        repeat (8) @(negedge clk);
        chk("v_stall_writes", w2_cnt - base, 0);
        chk("v_stall_busy", in_ready2, 0);
        chk("v_stall_addr", ram_addr2, 0);
        vblank = 1'b1;
        @(negedge clk);
        chk("v_sync1_we", ram_we2, 0);
        @(negedge clk);
        chk("v_sync2_we", ram_we2, 1);
        chk("v_addr", ram_addr2, 0);
        chk("v_data", ram_dataOut2, 16'h1E5A);
        @(negedge clk);
        chk("v_writes", w2_cnt - base, 1);
        chk("v_col", cursor_col2, 1);
        chk("v_we_off", ram_we2, 0);

        chk("we_oe_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
